// File: rtl/dvi_tx_pkg.sv
// Shared constants for the DVI transmit link sequencer: TMDS control tokens, clock-lane word,
// state encoding and the control-token lookup.
package dvi_tx_pkg;

    localparam int unsigned WORD_W  = 10;
    localparam int unsigned STATE_W = 3;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t CTRL_00  = 10'b1101010100;
    localparam word_t CTRL_01  = 10'b0010101011;
    localparam word_t CTRL_10  = 10'b0101010100;
    localparam word_t CTRL_11  = 10'b1010101011;
    localparam word_t CLK_WORD = 10'b1111100000;

    localparam logic [STATE_W-1:0] ST_OFF    = 3'd0;
    localparam logic [STATE_W-1:0] ST_SETTLE = 3'd1;
    localparam logic [STATE_W-1:0] ST_BLANK  = 3'd2;
    localparam logic [STATE_W-1:0] ST_ACTIVE = 3'd3;
    localparam logic [STATE_W-1:0] ST_DRAIN  = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        S_OFF    = ST_OFF,
        S_SETTLE = ST_SETTLE,
        S_BLANK  = ST_BLANK,
        S_ACTIVE = ST_ACTIVE,
        S_DRAIN  = ST_DRAIN
    } state_t;

    // Control token for {c1, c0} = {vsync, hsync} on the blue lane.
    function automatic word_t ctrl_token(input logic [1:0] c);
        word_t tok;
        case (c)
            2'b00:   tok = CTRL_00;
            2'b01:   tok = CTRL_01;
            2'b10:   tok = CTRL_10;
            default: tok = CTRL_11;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/dvi_tx_link_ctrl_if.sv
// Video bundle between the TMDS encoders, the link sequencer and the serializer.
// master = encoder/source side, slave = link sequencer.
interface dvi_tx_link_ctrl_if;

    logic              de;
    logic              hsync;
    logic              vsync;
    dvi_tx_pkg::word_t enc_b;
    dvi_tx_pkg::word_t enc_g;
    dvi_tx_pkg::word_t enc_r;
    dvi_tx_pkg::word_t data_b;
    dvi_tx_pkg::word_t data_g;
    dvi_tx_pkg::word_t data_r;
    dvi_tx_pkg::word_t data_c;

    modport master (
        output de, hsync, vsync, enc_b, enc_g, enc_r,
        input  data_b, data_g, data_r, data_c
    );

    modport slave (
        input  de, hsync, vsync, enc_b, enc_g, enc_r,
        output data_b, data_g, data_r, data_c
    );

endinterface

// File: rtl/dvi_tx_settle_timer.sv
// 16-bit PLL settle counter with clear/enable; done_c flags a count of SETTLE_CYCLES-1.
module dvi_tx_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done_c
);

    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign done_c = (cnt == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/dvi_tx_link_ctrl.sv
// DVI transmit link sequencer: brings the link up after PLL lock, gates video and inserts control
// tokens. Optional statistics counters are built when DVI_TX_LINK_CTRL_STATS_EN is defined.
module dvi_tx_link_ctrl
    import dvi_tx_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned BLANK_FRAMES  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pll_locked,
    input  logic                     tx_enable,
    dvi_tx_link_ctrl_if.slave        vid,
    output logic                     link_up,
    output logic [STATE_W-1:0]       state_o
`ifdef DVI_TX_LINK_CTRL_STATS_EN
    ,
    output logic [7:0]               lock_loss_cnt,
    output logic [15:0]              frame_cnt
`endif
);

    localparam int unsigned FRAME_W = 4;

    state_t             state;
    state_t             state_nxt;
    logic               vsync_d;
    logic               vs_rise_c;
    logic [FRAME_W-1:0] frames;
    logic               frame_hit_c;
    logic               settle_done_c;
    word_t              word_b_c, word_g_c, word_r_c, word_c_c;
    word_t              data_b_q, data_g_q, data_r_q, data_c_q;

    assign vs_rise_c   = vid.vsync & ~vsync_d;
    assign frame_hit_c = vs_rise_c && ((frames + FRAME_W'(1)) == FRAME_W'(BLANK_FRAMES));

    dvi_tx_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == S_OFF),
        .en     (state == S_SETTLE),
        .done_c (settle_done_c)
    );

    // Next-state logic; lock loss has priority over every other transition.
    always_comb begin
        state_nxt = S_OFF;
        case (state)
            S_OFF:    state_nxt = (tx_enable && pll_locked) ? S_SETTLE : S_OFF;
            S_SETTLE: begin
                if (!pll_locked || !tx_enable) state_nxt = S_OFF;
                else if (settle_done_c)        state_nxt = S_BLANK;
                else                           state_nxt = S_SETTLE;
            end
            S_BLANK: begin
                if (!pll_locked || !tx_enable) state_nxt = S_OFF;
                else if (frame_hit_c)          state_nxt = S_ACTIVE;
                else                           state_nxt = S_BLANK;
            end
            S_ACTIVE: begin
                if (!pll_locked)     state_nxt = S_OFF;
                else if (!tx_enable) state_nxt = S_DRAIN;
                else                 state_nxt = S_ACTIVE;
            end
            S_DRAIN: begin
                if (!pll_locked)    state_nxt = S_OFF;
                else if (tx_enable) state_nxt = S_ACTIVE;
                else if (vs_rise_c) state_nxt = S_OFF;
                else                state_nxt = S_DRAIN;
            end
            default:  state_nxt = S_OFF;
        endcase
    end

    // Lane words from the pre-transition state; de only matters once video is flowing.
    always_comb begin
        word_b_c = '0;
        word_g_c = '0;
        word_r_c = '0;
        word_c_c = '0;
        if (state == S_BLANK || state == S_ACTIVE || state == S_DRAIN) begin
            word_c_c = CLK_WORD;
            if (state != S_BLANK && vid.de) begin
                word_b_c = vid.enc_b;
                word_g_c = vid.enc_g;
                word_r_c = vid.enc_r;
            end else begin
                word_b_c = ctrl_token({vid.vsync, vid.hsync});
                word_g_c = ctrl_token(2'b00);
                word_r_c = ctrl_token(2'b00);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_OFF;
            vsync_d  <= 1'b0;
            frames   <= '0;
            data_b_q <= '0;
            data_g_q <= '0;
            data_r_q <= '0;
            data_c_q <= '0;
            link_up  <= 1'b0;
            state_o  <= ST_OFF;
        end else begin
            state    <= state_nxt;
            vsync_d  <= vid.vsync;
            if (state == S_OFF || (state == S_SETTLE && state_nxt == S_BLANK)) begin
                frames <= '0;
            end else if (state == S_BLANK && vs_rise_c) begin
                frames <= frames + FRAME_W'(1);
            end
            data_b_q <= word_b_c;
            data_g_q <= word_g_c;
            data_r_q <= word_r_c;
            data_c_q <= word_c_c;
            link_up  <= (state_nxt == S_ACTIVE) || (state_nxt == S_DRAIN);
            state_o  <= state_nxt;
        end
    end

    assign vid.data_b = data_b_q;
    assign vid.data_g = data_g_q;
    assign vid.data_r = data_r_q;
    assign vid.data_c = data_c_q;

`ifdef DVI_TX_LINK_CTRL_STATS_EN
    // Lock-loss shutdowns (saturating) and frames delivered while ACTIVE (wrapping).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_loss_cnt <= '0;
            frame_cnt     <= '0;
        end else begin
            if (!pll_locked && (state inside {S_SETTLE, S_BLANK, S_ACTIVE, S_DRAIN})
                && lock_loss_cnt != 8'hFF) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
            if (state == S_ACTIVE && vs_rise_c) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/dvi_tx_link_ctrl.md
Name: dvi_tx_link_ctrl

Overview:
Link sequencer in front of the 4-lane 10:1 DVI serializer, in the pixel clock (clk) domain.
- Brings the link up cleanly after reset and after PLL lock.
- Gates video from the TMDS encoders.
- Substitutes control tokens during blanking and link start-up.
- Drives the constant clock-lane word.
- Shuts the link down on lock loss or software disable.

Parameters:
SETTLE_CYCLES, 1024, clk cycles pll_locked must stay high before leaving SETTLE (legal range 2..65535).
BLANK_FRAMES, 1, vsync rising edges seen in BLANK before entering ACTIVE (legal range 1..15).

Ports:
clk  in  1  pixel clock; single clock domain.
rst_n  in  1  synchronous, active-low reset.
pll_locked  in  1  serializer PLL lock, already synchronized to clk.
tx_enable  in  1  software link enable.
de  in  1  active-video flag, aligned with enc_*.
hsync  in  1  active-high horizontal sync.
vsync  in  1  active-high vertical sync.
enc_b, enc_g, enc_r  in  10 each  TMDS-encoded pixel words.
data_b, data_g, data_r, data_c  out  10 each  words to the serializer.
link_up  out  1  high in ACTIVE and DRAIN.
state_o  out  3  current state encoding.

Behaviour:
- Reset (rst_n=0 on a clk edge): state=OFF; all data_* outputs=0; link_up=0; state_o=0; vsync_d=0; settle counter=0; frame counter=0.
- States and encoding: OFF=0, SETTLE=1, BLANK=2, ACTIVE=3, DRAIN=4. Codes 5-7 are illegal and recover to OFF on the next cycle.
- Vsync edge detect: vs_rise = vsync & ~vsync_d; vsync_d is registered every cycle.
- OFF:
  - Clears both counters.
  - tx_enable && pll_locked -> SETTLE.
- SETTLE:
  - Settle counter (16 bit) increments each cycle.
  - !pll_locked or !tx_enable -> OFF.
  - Counter == SETTLE_CYCLES-1 -> BLANK; frame counter cleared.
- BLANK:
  - Frame counter (4 bit) increments on vs_rise.
  - On the vs_rise that brings the count to BLANK_FRAMES -> ACTIVE.
  - !pll_locked or !tx_enable -> OFF.
- ACTIVE:
  - !pll_locked -> OFF (takes priority).
  - else !tx_enable -> DRAIN.
- DRAIN:
  - !pll_locked -> OFF.
  - else tx_enable -> ACTIVE.
  - else vs_rise -> OFF (graceful stop at the frame boundary).
- Simultaneous events: lock loss beats every other transition. In BLANK, a vs_rise with !tx_enable goes to OFF.
- Output words are registered, 1-cycle latency. Outputs at edge n+1 are a function of the state and inputs sampled at edge n, using the pre-transition state.
  - OFF, SETTLE: data_b/g/r/c = 0.
  - BLANK: data_c = 10'b1111100000; data_b = CTRL({vsync,hsync}); data_g = data_r = CTRL(2'b00). de is ignored.
  - ACTIVE, DRAIN: data_c = 10'b1111100000. If de=1, data_b/g/r = enc_b/g/r; if de=0, use the control tokens as in BLANK.
- Control token map CTRL(c1,c0):
  - 00 -> 10'b1101010100
  - 01 -> 10'b0010101011
  - 10 -> 10'b0101010100
  - 11 -> 10'b1010101011
- link_up and state_o are registered from the next-state value, so they change on the same edge as the state register.

Optional Feature:
DVI_TX_LINK_CTRL_STATS_EN
- Defined: adds two outputs, lock_loss_cnt[7:0] and frame_cnt[15:0].
  - lock_loss_cnt increments, saturating at 255, on every transition to OFF caused by !pll_locked from SETTLE, BLANK, ACTIVE or DRAIN.
  - frame_cnt increments, wrapping, on vs_rise while in ACTIVE.
  - Both counters are cleared only by reset.
- Not defined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package dvi_tx_pkg holds:
  - the four control-token constants
  - the clock-lane word 10'b1111100000
  - the 3-bit state encoding constants
  - the CTRL token lookup function
- One sub-module, dvi_tx_settle_timer: the 16-bit settle counter with clear/enable and a done flag at SETTLE_CYCLES-1. Everything else stays in the top.

Test Plan:
1. SETTLE_CYCLES=8, BLANK_FRAMES=1; release reset with tx_enable=1, pll_locked=1 -> SETTLE for exactly 8 cycles; BLANK entered with data_c=1111100000 and data_b=1101010100 while syncs are 0.
2. In BLANK, drive hsync=1, vsync=1, de=1 -> data_b=1010101011 and data_g=data_r=1101010100 one cycle later (de ignored); ACTIVE is entered on that vsync rise.
3. In ACTIVE with de=1 and enc_r=10'h2AB -> data_r=10'h2AB after 1 cycle; with de=0, hsync=1 -> data_b=0010101011.
4. In ACTIVE, deassert tx_enable -> state 4 and video still passes; next vsync rise -> OFF, all data_*=0, link_up=0.
5. Drop pll_locked for 1 cycle during ACTIVE, with tx_enable=0 in the same cycle -> OFF next edge (lock loss wins); with STATS_EN defined, lock_loss_cnt=1.
6. Assert rst_n=0 mid-ACTIVE -> next edge: state_o=0, data_* outputs=0; with STATS_EN defined, frame_cnt=0.
